wb_nic: RTL and testbench

- Parametrised single-master Wishbone interconnect, placed between rv_core and its N slaves (TCM, UART, I2C, CCM...).
- Decodes the top ADDR_SEL_WIDTH address bits to one slave slot and latches that selection for the whole transaction.
- Registers the slave response back to the master.
- Answers unmapped addresses and hung slaves with o_wb_err, so the core never stalls forever.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_bus_timer.sv | 24 ++
 rtl/wb_nic.sv | 117 +++++++++++
 tb/tb_wb_nic.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the single-master Wishbone interconnect.
package wb_pkg;

  typedef enum logic [1:0] {WB_IDLE, WB_BUSY, WB_RESP} wb_state_t;

  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_ADDR_SEL_WIDTH = 4;
  localparam int WB_MAX_SLOTS      = 256;

  // Callers size-cast the result down to their own slot count.
  function automatic logic [WB_MAX_SLOTS-1:0] onehot(input logic [7:0] slot, input int n);
    onehot = '0;
    if (32'(slot) < n) onehot[slot] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_bus_timer.sv
// Saturating busy-cycle counter; flags the last permitted cycle of a slave access.
module wb_bus_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] MAX  = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear)              count <= '0;
    else if (enable && count != MAX) count <= count + 1'b1;
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/wb_nic.sv
// Single-master Wishbone interconnect: top-bits decode, latched slot, registered
// response, error on unmapped slots and on slaves that never acknowledge.
module wb_nic
  import wb_pkg::*;
#(
  parameter int ADDR_SEL_WIDTH = WB_ADDR_SEL_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter logic [(1<<ADDR_SEL_WIDTH)-1:0] SLAVE_MASK = 'h0001,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic [31:0]                              i_wb_adr,
  input  logic [DATA_WIDTH-1:0]                    i_wb_dat,
  output logic [DATA_WIDTH-1:0]                    o_wb_dat,
  input  logic                                     i_wb_we,
  input  logic [DATA_WIDTH/8-1:0]                  i_wb_sel,
  input  logic                                     i_wb_stb,
  input  logic                                     i_wb_cyc,
  output logic                                     o_wb_ack,
  output logic                                     o_wb_err,
  output logic [31:0]                              o_slv_adr,
  output logic [DATA_WIDTH-1:0]                    o_slv_dat,
  output logic                                     o_slv_we,
  output logic [DATA_WIDTH/8-1:0]                  o_slv_sel,
  output logic [(1<<ADDR_SEL_WIDTH)-1:0]           o_slv_stb,
  output logic [(1<<ADDR_SEL_WIDTH)-1:0]           o_slv_cyc,
  input  logic [(1<<ADDR_SEL_WIDTH)-1:0]           i_slv_ack,
  input  logic [(1<<ADDR_SEL_WIDTH)*DATA_WIDTH-1:0] i_slv_dat
);
  localparam int N = 1 << ADDR_SEL_WIDTH;

  wb_state_t                 state;
  logic [ADDR_SEL_WIDTH-1:0] slot_q;
  logic [ADDR_SEL_WIDTH-1:0] req_slot;
  logic [N-1:0]              req_oh;
  logic                      req_mapped;
  logic [DATA_WIDTH-1:0]     slot_dat;
  logic                      expired;

  assign req_slot   = i_wb_adr[31 -: ADDR_SEL_WIDTH];
  assign req_oh     = N'(onehot(8'(req_slot), N));
  assign req_mapped = SLAVE_MASK[req_slot];
  assign slot_dat   = i_slv_dat[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH];

  wb_bus_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (i_clk),
    .rst     (i_reset),
    .clear   (state != WB_BUSY),
    .enable  (state == WB_BUSY),
    .expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= WB_IDLE;
      slot_q    <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_dat  <= '0;
      o_slv_adr <= '0;
      o_slv_dat <= '0;
      o_slv_we  <= 1'b0;
      o_slv_sel <= '0;
      o_slv_stb <= '0;
      o_slv_cyc <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            if (req_mapped) begin
              slot_q    <= req_slot;
              o_slv_adr <= i_wb_adr;
              o_slv_dat <= i_wb_dat;
              o_slv_we  <= i_wb_we;
              o_slv_sel <= i_wb_sel;
              o_slv_stb <= req_oh;
              o_slv_cyc <= req_oh;
              state     <= WB_BUSY;
            end else begin
              o_wb_err <= 1'b1;
              state    <= WB_RESP;
            end
          end
        end
        WB_BUSY: begin
          // A master abort takes precedence: the transaction vanishes without a response.
          if (!i_wb_cyc) begin
            o_slv_stb <= '0;
            o_slv_cyc <= '0;
            o_slv_adr <= '0;
            o_slv_dat <= '0;
            o_slv_we  <= 1'b0;
            o_slv_sel <= '0;
            state     <= WB_IDLE;
          end else if (i_slv_ack[slot_q]) begin
            o_wb_dat  <= slot_dat;
            o_wb_ack  <= 1'b1;
            o_slv_stb <= '0;
            o_slv_cyc <= '0;
            state     <= WB_RESP;
          end else if (expired) begin
            o_wb_err  <= 1'b1;
            o_slv_stb <= '0;
            o_slv_cyc <= '0;
            state     <= WB_RESP;
          end
        end
        WB_RESP: state <= WB_IDLE;
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_nic.sv
// Randomized self-checking bench for wb_nic against a cycle-count response model.
module tb_wb_nic;
  localparam int ASW = 4;
  localparam int DW  = 32;
  localparam int N   = 1 << ASW;
  localparam logic [N-1:0] MASK = 16'h0003;
  localparam int TO  = 8;
  localparam int NEVER = 1000;

  logic              i_clk = 0;
  logic              i_reset;
  logic [31:0]       i_wb_adr;
  logic [DW-1:0]     i_wb_dat;
  logic [DW-1:0]     o_wb_dat;
  logic              i_wb_we;
  logic [DW/8-1:0]   i_wb_sel;
  logic              i_wb_stb;
  logic              i_wb_cyc;
  logic              o_wb_ack;
  logic              o_wb_err;
  logic [31:0]       o_slv_adr;
  logic [DW-1:0]     o_slv_dat;
  logic              o_slv_we;
  logic [DW/8-1:0]   o_slv_sel;
  logic [N-1:0]      o_slv_stb;
  logic [N-1:0]      o_slv_cyc;
  logic [N-1:0]      i_slv_ack;
  logic [N*DW-1:0]   i_slv_dat;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_rd;
  bit          last_known = 0;

  always #5 i_clk = ~i_clk;

  wb_nic #(.ADDR_SEL_WIDTH(ASW), .DATA_WIDTH(DW), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat),
    .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel), .i_wb_stb(i_wb_stb), .i_wb_cyc(i_wb_cyc),
    .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_slv_adr(o_slv_adr), .o_slv_dat(o_slv_dat), .o_slv_we(o_slv_we), .o_slv_sel(o_slv_sel),
    .o_slv_stb(o_slv_stb), .o_slv_cyc(o_slv_cyc),
    .i_slv_ack(i_slv_ack), .i_slv_dat(i_slv_dat)
  );

  // Reference: response cycle counted from the request cycle (cycle 0).
  function automatic int exp_cycle(input int slot, input int d);
    if (!MASK[slot]) return 1;
    if (d <= TO - 1) return d + 2;
    return TO + 1;
  endfunction

  function automatic bit exp_is_err(input int slot, input int d);
    return !MASK[slot] || d > TO - 1;
  endfunction

  // Issue one request; a slave acks on its d-th strobe cycle (0-based).
  task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input int d, input bit ovr, input logic [31:0] ovr_dat,
                        output int resp_cyc, output bit resp_err, output logic [31:0] rdata,
                        output logic [31:0] lane);
    int slot;
    int stbc;
    logic [N-1:0] exp_oh;
    slot = int'(adr[31:28]);
    exp_oh = '0;
    exp_oh[slot] = 1'b1;
    for (int k = 0; k < N; k++) i_slv_dat[k*DW +: DW] = $urandom;
    if (ovr) i_slv_dat[slot*DW +: DW] = ovr_dat;
    lane = i_slv_dat[slot*DW +: DW];
    resp_cyc = -1;
    resp_err = 0;
    rdata = '0;
    stbc = 0;
    @(negedge i_clk);
    i_wb_adr = adr; i_wb_we = we; i_wb_dat = dat; i_wb_sel = sel;
    i_wb_stb = 1; i_wb_cyc = 1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge i_clk); #1;
      i_slv_ack = '0;
      if (o_wb_ack || o_wb_err) begin
        resp_cyc = c;
        resp_err = o_wb_err;
        rdata = o_wb_dat;
        checks++;
        if (o_wb_ack && o_wb_err) begin
          errors++;
          $display("FAIL ack_err_exclusive: got ack=%0b err=%0b required one only", o_wb_ack, o_wb_err);
        end
        break;
      end
      if (o_slv_stb != '0 || o_slv_cyc != '0) begin
        checks++;
        if (o_slv_stb !== exp_oh || o_slv_cyc !== exp_oh || !MASK[slot]) begin
          errors++;
          $display("FAIL slave_strobe: got stb=%h cyc=%h required %h (mapped=%0b)",
                   o_slv_stb, o_slv_cyc, exp_oh, MASK[slot]);
        end
        if (stbc == 0) begin
          checks++;
          if (o_slv_adr !== adr || o_slv_dat !== dat || o_slv_we !== we || o_slv_sel !== sel) begin
            errors++;
            $display("FAIL slave_bus: got adr=%h dat=%h we=%0b sel=%h required %h %h %0b %h",
                     o_slv_adr, o_slv_dat, o_slv_we, o_slv_sel, adr, dat, we, sel);
          end
        end
        if (stbc == d) i_slv_ack[slot] = 1'b1;
        stbc++;
      end
    end
    i_wb_stb = 0; i_wb_cyc = 0; i_slv_ack = '0;
    @(posedge i_clk); #1;
    checks++;
    if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0 || o_slv_stb !== '0) begin
      errors++;
      $display("FAIL single_cycle_resp: got ack=%0b err=%0b stb=%h required 0 0 0", o_wb_ack, o_wb_err, o_slv_stb);
    end
  endtask

  task automatic check_resp(input string name, input int slot, input int d, input logic we,
                            input int rc, input bit re, input logic [31:0] rd, input logic [31:0] lane);
    int  ec;
    bit  ee;
    ec = exp_cycle(slot, d);
    ee = exp_is_err(slot, d);
    checks++;
    if (rc != ec || re != ee) begin
      errors++;
      $display("FAIL %s_resp: got cycle=%0d err=%0b required cycle=%0d err=%0b", name, rc, re, ec, ee);
    end
    if (!ee && !we) begin
      checks++;
      if (rd !== lane) begin
        errors++;
        $display("FAIL %s_rdata: got %h required %h", name, rd, lane);
      end
    end else if (ee && last_known) begin
      checks++;
      if (rd !== last_rd) begin
        errors++;
        $display("FAIL %s_rdata_hold: got %h required %h", name, rd, last_rd);
      end
    end
    if (!ee) begin
      last_known = !we;
      last_rd = lane;
    end
  endtask

  task automatic test_reset();
    i_reset = 1; i_wb_stb = 0; i_wb_cyc = 0; i_wb_adr = '0; i_wb_dat = '0; i_wb_we = 0;
    i_wb_sel = '0; i_slv_ack = '0; i_slv_dat = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_wb_ack !== 0 || o_wb_err !== 0 || o_wb_dat !== '0 || o_slv_stb !== '0 || o_slv_cyc !== '0) begin
      errors++;
      $display("FAIL reset_master: got ack=%0b err=%0b dat=%h stb=%h cyc=%h required all 0",
               o_wb_ack, o_wb_err, o_wb_dat, o_slv_stb, o_slv_cyc);
    end
    checks++;
    if (o_slv_adr !== '0 || o_slv_dat !== '0 || o_slv_we !== 0 || o_slv_sel !== '0) begin
      errors++;
      $display("FAIL reset_bcast: got adr=%h dat=%h we=%0b sel=%h required all 0",
               o_slv_adr, o_slv_dat, o_slv_we, o_slv_sel);
    end
    i_reset = 0;
    last_known = 0;
  endtask

  task automatic test_read();
    int rc; bit re; logic [31:0] rd, ln;
    do_txn(32'h1000_0004, 0, 32'h0, 4'hF, 0, 1, 32'hDEAD_BEEF, rc, re, rd, ln);
    check_resp("read", 1, 0, 0, rc, re, rd, ln);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_deadbeef: got %h required deadbeef", rd);
    end
  endtask

  task automatic test_write();
    int rc; bit re; logic [31:0] rd, ln;
    do_txn(32'h0000_0010, 1, 32'h1234_5678, 4'b0011, 1, 0, 0, rc, re, rd, ln);
    check_resp("write", 0, 1, 1, rc, re, rd, ln);
  endtask

  task automatic test_unmapped();
    int rc; bit re; logic [31:0] rd, ln;
    do_txn(32'h5000_0000, 0, 32'h0, 4'hF, 0, 0, 0, rc, re, rd, ln);
    check_resp("unmapped", 5, 0, 0, rc, re, rd, ln);
  endtask

  task automatic test_timeout();
    int rc; bit re; logic [31:0] rd, ln;
    do_txn(32'h0000_0100, 0, 32'h0, 4'hF, NEVER, 0, 0, rc, re, rd, ln);
    check_resp("timeout", 0, NEVER, 0, rc, re, rd, ln);
    do_txn(32'h0000_0104, 0, 32'h0, 4'hF, 2, 0, 0, rc, re, rd, ln);
    check_resp("after_timeout", 0, 2, 0, rc, re, rd, ln);
  endtask

  task automatic test_ack_timeout_tie();
    int rc; bit re; logic [31:0] rd, ln;
    do_txn(32'h1000_0008, 0, 32'h0, 4'hF, TO - 1, 0, 0, rc, re, rd, ln);
    check_resp("tie", 1, TO - 1, 0, rc, re, rd, ln);
  endtask

  task automatic test_abort_reset();
    @(negedge i_clk);
    i_wb_adr = 32'h1000_0000; i_wb_we = 0; i_wb_stb = 1; i_wb_cyc = 1; i_slv_ack = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_slv_stb !== 16'h0002) begin
      errors++;
      $display("FAIL abort_reset_busy: got stb=%h required 0002", o_slv_stb);
    end
    i_reset = 1;
    @(posedge i_clk); #1;
    i_reset = 0; i_wb_stb = 0; i_wb_cyc = 0;
    checks++;
    if (o_slv_stb !== '0 || o_slv_cyc !== '0 || o_wb_ack !== 0 || o_wb_err !== 0 || o_wb_dat !== '0) begin
      errors++;
      $display("FAIL abort_reset_outputs: got stb=%h cyc=%h ack=%0b err=%0b dat=%h required all 0",
               o_slv_stb, o_slv_cyc, o_wb_ack, o_wb_err, o_wb_dat);
    end
    repeat (3) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_wb_ack !== 0 || o_wb_err !== 0) begin
        errors++;
        $display("FAIL abort_reset_silent: got ack=%0b err=%0b required 0 0", o_wb_ack, o_wb_err);
      end
    end
    last_known = 0;
  endtask

  task automatic test_abort_cyc();
    int rc; bit re; logic [31:0] rd, ln;
    @(negedge i_clk);
    i_wb_adr = 32'h1000_0000; i_wb_we = 0; i_wb_stb = 1; i_wb_cyc = 1;
    i_slv_ack = '0; i_slv_ack[2] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_slv_stb !== 16'h0002 || o_wb_ack !== 0 || o_wb_err !== 0) begin
        errors++;
        $display("FAIL stray_ack_c%0d: got stb=%h ack=%0b err=%0b required 0002 0 0", c, o_slv_stb, o_wb_ack, o_wb_err);
      end
    end
    i_wb_stb = 0; i_wb_cyc = 0;
    repeat (3) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_slv_stb !== '0 || o_slv_cyc !== '0 || o_wb_ack !== 0 || o_wb_err !== 0) begin
        errors++;
        $display("FAIL abort_cyc: got stb=%h cyc=%h ack=%0b err=%0b required 0", o_slv_stb, o_slv_cyc, o_wb_ack, o_wb_err);
      end
    end
    i_slv_ack = '0;
    do_txn(32'h1000_0020, 0, 32'h0, 4'hF, 1, 0, 0, rc, re, rd, ln);
    check_resp("after_abort", 1, 1, 0, rc, re, rd, ln);
  endtask

  task automatic test_random();
    int rc; bit re; logic [31:0] rd, ln;
    int slot, d;
    logic we;
    logic [31:0] adr;
    for (int t = 0; t < 40; t++) begin
      slot = ($urandom_range(0, 4) == 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 3);
      d    = $urandom_range(0, TO + 1);
      we   = 1'($urandom_range(0, 1));
      adr  = {4'(slot), 28'($urandom)};
      do_txn(adr, we, $urandom, 4'($urandom), d, 0, 0, rc, re, rd, ln);
      check_resp("random", slot, d, we, rc, re, rd, ln);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_ack_timeout_tie();
    test_abort_reset();
    test_abort_cyc();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
